// File: rtl/lsu_mem_master_if.sv
// Request/response and data-memory signals of the load/store initiator.
// The master modport is the initiator's view; slave is the pipeline/memory side.
interface lsu_mem_master_if #(
    parameter int unsigned ADDR_WID = 29
);
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [2:0]          req_funct3;
    logic [63:0]         req_addr;
    logic [63:0]         req_wdata;

    logic                resp_valid;
    logic [63:0]         resp_rdata;
    logic                resp_err;
    logic                resp_split;

    logic [ADDR_WID-1:0] mem_addr;
    logic [63:0]         mem_rdata;
    logic                mem_wr_en;
    logic [63:0]         mem_wdata;
    logic [7:0]          mem_wmask;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_split,
        output mem_addr, mem_wr_en, mem_wdata, mem_wmask
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_split,
        input  mem_addr, mem_wr_en, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_mem_master.sv
// RV64 load/store initiator for a doubleword memory with async read and byte-masked sync write.
// Doubleword-crossing accesses are split into two beats (or rejected when ALLOW_SPLIT=0).
module lsu_mem_master #(
    parameter int unsigned ADDR_WID    = 29,
    parameter bit          ALLOW_SPLIT = 1'b1
) (
    input logic              clk,
    input logic              rst,
    lsu_mem_master_if.master bus
);

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

    state_e              state_q;
    logic                we_q;
    logic [2:0]          funct3_q;
    logic [2:0]          off_q;
    logic [ADDR_WID-1:0] dw_q;
    logic [63:0]         wdata_q;
    logic [63:0]         lo_q;
    logic                cross_q;
    logic [63:0]         resp_rdata_q;
    logic                resp_err_q;
    logic                resp_split_q;

    function automatic logic [7:0] size_ones(input logic [1:0] sz);
        logic [7:0] ones;
        case (sz)
            2'b00:   ones = 8'h01;
            2'b01:   ones = 8'h03;
            2'b10:   ones = 8'h0F;
            default: ones = 8'hFF;
        endcase
        return ones;
    endfunction

    // raw = {hi, lo}; shift the addressed bytes down to lane 0, then extend.
    function automatic logic [63:0] load_extract(input logic [127:0] raw, input logic [2:0] off,
                                                 input logic [2:0] f3);
        logic [127:0] r;
        logic [63:0]  ext;
        r = raw >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   ext = f3[2] ? {56'b0, r[7:0]}  : {{56{r[7]}}, r[7:0]};
            2'b01:   ext = f3[2] ? {48'b0, r[15:0]} : {{48{r[15]}}, r[15:0]};
            2'b10:   ext = f3[2] ? {32'b0, r[31:0]} : {{32{r[31]}}, r[31:0]};
            default: ext = r[63:0];
        endcase
        return ext;
    endfunction

    logic [2:0] req_off;
    logic [3:0] req_n;
    logic       req_cross;
    logic       req_illegal;

    always_comb begin
        req_off     = bus.req_addr[2:0];
        req_n       = 4'd1 << bus.req_funct3[1:0];
        req_cross   = (({1'b0, req_off} + req_n) > 4'd8);
        req_illegal = (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]) ||
                      (!ALLOW_SPLIT && req_cross);
    end

    logic [15:0]  lane_mask;
    logic [127:0] lane_data;

    always_comb begin
        lane_mask = {8'b0, size_ones(funct3_q[1:0])} << off_q;
        lane_data = {64'b0, wdata_q} << {off_q, 3'b000};
    end

    // Memory side is idle outside beats and silenced by reset even mid-beat.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wr_en = 1'b0;
        bus.mem_wmask = 8'h00;
        bus.mem_wdata = 64'h0;
        if (!rst) begin
            case (state_q)
                StBeat0: begin
                    bus.mem_addr = dw_q;
                    if (we_q) begin
                        bus.mem_wr_en = 1'b1;
                        bus.mem_wmask = lane_mask[7:0];
                        bus.mem_wdata = lane_data[63:0];
                    end
                end
                StBeat1: begin
                    bus.mem_addr = dw_q + {{(ADDR_WID-1){1'b0}}, 1'b1};
                    if (we_q) begin
                        bus.mem_wr_en = 1'b1;
                        bus.mem_wmask = lane_mask[15:8];
                        bus.mem_wdata = lane_data[127:64];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == StIdle) && !rst;
    assign bus.resp_valid = (state_q == StResp) && !rst;
    assign bus.resp_rdata = bus.resp_valid ? resp_rdata_q : 64'h0;
    assign bus.resp_err   = bus.resp_valid && resp_err_q;
    assign bus.resp_split = bus.resp_valid && resp_split_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 3'b000;
            dw_q         <= '0;
            wdata_q      <= 64'h0;
            lo_q         <= 64'h0;
            cross_q      <= 1'b0;
            resp_rdata_q <= 64'h0;
            resp_err_q   <= 1'b0;
            resp_split_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        off_q    <= req_off;
                        dw_q     <= bus.req_addr[ADDR_WID+2:3];
                        wdata_q  <= bus.req_wdata;
                        cross_q  <= req_cross;
                        if (req_illegal) begin
                            resp_err_q <= 1'b1;
                            state_q    <= StResp;
                        end else begin
                            state_q <= StBeat0;
                        end
                    end
                end
                StBeat0: begin
                    lo_q <= bus.mem_rdata;
                    if (cross_q) begin
                        state_q <= StBeat1;
                    end else begin
                        resp_rdata_q <= we_q ? 64'h0 :
                                        load_extract({64'h0, bus.mem_rdata}, off_q, funct3_q);
                        state_q      <= StResp;
                    end
                end
                StBeat1: begin
                    resp_rdata_q <= we_q ? 64'h0 :
                                    load_extract({bus.mem_rdata, lo_q}, off_q, funct3_q);
                    resp_split_q <= 1'b1;
                    state_q      <= StResp;
                end
                StResp: begin
                    resp_rdata_q <= 64'h0;
                    resp_err_q   <= 1'b0;
                    resp_split_q <= 1'b0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[63:ADDR_WID+3];

endmodule
